mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
Multi-cycle successor to the single-cycle MIPS datapath. One shared memory port is used for both instruction fetch and data access, with a req/ack handshake that tolerates wait states. An internal FSM sequences FETCH/DECODE/EXEC/MEM/WB. The instruction set adds ADDI, J, SYSCALL-halt and an illegal-instruction trap. Address width and reset vector are parameters.

Parameters:
ADDR_WIDTH, 16, width of mem_addr and of the PC; byte address, upper PC/ALU bits truncated.
RESET_PC, 0, PC value loaded on reset; must be word-aligned.
NUM_REGS, 32, register-file entries (power of 2, ≤32); register indices ≥NUM_REGS raise a trap.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
mem_req  output  1  memory transaction request, held high until mem_ack
mem_we  output  1  1=write (SW), 0=read (fetch/LW); stable while mem_req=1
mem_addr  output  ADDR_WIDTH  byte address, word-aligned; stable while mem_req=1
mem_wdata  output  32  store data; stable while mem_req=1
mem_rdata  input  32  read data, sampled in the cycle mem_ack=1
mem_ack  input  1  completes the transaction in the same cycle; may be high in the first req cycle
halted  output  1  sticky; set by SYSCALL or trap, cleared only by reset
trap  output  1  sticky; set by illegal opcode/funct, misaligned LW/SW, or bad register index
instr_retired  output  1  one-cycle pulse when an instruction completes
pc_out  output  ADDR_WIDTH  PC of the instruction currently executing

Behaviour:
- Reset (async assert, sync release): state=FETCH, PC=RESET_PC, all regs=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, trap=0, instr_retired=0. Asserting reset during a pending req drops mem_req immediately.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ack: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE (1 cycle): A<=R[rs], B<=R[rt], branch target T<=PC+(sext(imm)<<2), where PC is already PC+4. Illegal opcode/funct or a register index ≥NUM_REGS → TRAP. IR=0x0000000C → HALT.
- EXEC (1 cycle):
  - R-type: ADD/SUB mod 2^32 with no overflow trap; AND, OR; SLT signed gives 1 or 0.
  - LW/SW/ADDI: A+sext(imm).
  - BEQ: if A==B, PC<=T; retire; → FETCH.
  - J: PC<={PC[ADDR_WIDTH-1:28 when wider], imm26, 2'b00} truncated to ADDR_WIDTH; retire; → FETCH.
  - R-type/ADDI → WB. LW/SW → MEM, or TRAP if the address is misaligned (addr[1:0]≠0).
- MEM:
  - SW: mem_req=1, mem_we=1, mem_addr=ALUout, mem_wdata=B. On ack: retire, → FETCH.
  - LW: read; on ack MDR<=mem_rdata, → WB.
- WB (1 cycle): rd (R-type) or rt (LW/ADDI) <= result; retire; → FETCH.
- Writes to R0 are discarded; R0 always reads 0.
- Cycle counts with zero-wait ack: BEQ/J 3, R/ADDI/SW 4, LW 5. Each wait cycle adds 1 per memory access.
- HALT/TRAP: terminal states. mem_req=0, halted=1 (trap=1 in TRAP), no retire pulse, PC frozen at the faulting instruction+4.
- mem_ack while mem_req=0 is ignored. mem_rdata is ignored except in the ack cycle.

Test Plan:
- Reset with RESET_PC=0x40, zero-wait memory → first mem_addr=0x40; all outputs 0 until the first req.
- ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SLT r4,r2,r1 → r3=2, r4=1; four instr_retired pulses; 16 cycles total.
- SW r1,8(r0) then LW r5,8(r0), with 3 wait cycles per access → write to addr 8 with data 5 held stable through the waits; r5=5; the LW takes 5+6 cycles.
- BEQ r1,r1,+2 at PC 0x10 → next fetch at 0x1C. BEQ r1,r2 not taken → next fetch at 0x14. J 0x100/4 → fetch at 0x100.
- Opcode 0x3F → trap=1, halted=1, mem_req stays 0. LW at addr 0x6 → trap. SYSCALL → halted=1, trap=0.
- reset_n low mid-FETCH while ack is stalled → mem_req drops the same cycle; after release, fetch restarts at RESET_PC. ADD r0,r1,r1 → r0 still reads 0.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared
// req/ack memory port, with ADDI, J, SYSCALL halt and an illegal-instruction trap.
module mips_multicycle_core #(
    parameter int          ADDR_WIDTH = 16,
    parameter int unsigned RESET_PC   = 0,
    parameter int          NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  halted,
    output logic                  trap,
    output logic                  instr_retired,
    output logic [ADDR_WIDTH-1:0] pc_out
);

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam int RIW = $clog2(NUM_REGS);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;
    localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic [31:0]           ir, a, b, alu_out, mdr;
    logic [31:0]           regs [NUM_REGS];

    logic [5:0]            opcode, funct;
    logic [4:0]            rs, rt, rd, dest;
    logic [31:0]           sext, branch_off, jump_full, alu_result, wb_value;
    logic                  legal, bad_index;
    logic [ADDR_WIDTH-1:0] next_pc;

    function automatic logic bad_reg(input logic [4:0] idx);
        return 32'(idx) >= 32'(NUM_REGS);
    endfunction

    assign opcode     = ir[31:26];
    assign rs         = ir[25:21];
    assign rt         = ir[20:16];
    assign rd         = ir[15:11];
    assign funct      = ir[5:0];
    assign sext       = {{16{ir[15]}}, ir[15:0]};
    assign branch_off = {sext[29:0], 2'b00};
    assign dest       = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_value   = (opcode == OP_LW) ? mdr : alu_out;

    always_comb begin
        legal     = 1'b1;
        bad_index = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal     = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
                bad_index = bad_reg(rs) | bad_reg(rt) | bad_reg(rd);
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: bad_index = bad_reg(rs) | bad_reg(rt);
            OP_J:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_result = a + b;
                    FN_SUB:  alu_result = a - b;
                    FN_AND:  alu_result = a & b;
                    FN_OR:   alu_result = a | b;
                    FN_SLT:  alu_result = {31'b0, $signed(a) < $signed(b)};
                    default: alu_result = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_result = a + sext;
            default: alu_result = '0;
        endcase
    end

    // pc already points past the jump, so its top nibble supplies the region bits
    always_comb begin
        jump_full        = 32'(pc);
        jump_full[27:0]  = {ir[25:0], 2'b00};
        next_pc          = pc;
        if (opcode == OP_J)
            next_pc = ADDR_WIDTH'(jump_full);
        else if (opcode == OP_BEQ && a == b)
            next_pc = target;
    end

    // Outputs are registered; every transition into FETCH/MEM presets the request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_FETCH;
            pc            <= RESET_ADDR;
            pc_out        <= RESET_ADDR;
            target        <= '0;
            ir            <= '0;
            a             <= '0;
            b             <= '0;
            alu_out       <= '0;
            mdr           <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            halted        <= 1'b0;
            trap          <= 1'b0;
            instr_retired <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            instr_retired <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        pc_out   <= pc;
                    end else if (mem_ack) begin
                        ir      <= mem_rdata;
                        pc      <= pc + PC_STEP;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a      <= regs[rs[RIW-1:0]];
                    b      <= regs[rt[RIW-1:0]];
                    target <= pc + ADDR_WIDTH'(branch_off);
                    if (ir == SYSCALL_WORD) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!legal || bad_index) begin
                        halted <= 1'b1;
                        trap   <= 1'b1;
                        state  <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    case (opcode)
                        OP_BEQ, OP_J: begin
                            pc            <= next_pc;
                            instr_retired <= 1'b1;
                            mem_req       <= 1'b1;
                            mem_we        <= 1'b0;
                            mem_addr      <= next_pc;
                            pc_out        <= next_pc;
                            state         <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            if (alu_result[1:0] != 2'b00) begin
                                halted <= 1'b1;
                                trap   <= 1'b1;
                                state  <= S_TRAP;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_we   <= (opcode == OP_SW);
                                mem_addr <= ADDR_WIDTH'(alu_result);
                                if (opcode == OP_SW) mem_wdata <= b;
                                state    <= S_MEM;
                            end
                        end
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (mem_we) begin
                            instr_retired <= 1'b1;
                            mem_addr      <= pc;
                            pc_out        <= pc;
                            state         <= S_FETCH;
                        end else begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dest != 5'd0) regs[dest[RIW-1:0]] <= wb_value;
                    instr_retired <= 1'b1;
                    mem_req       <= 1'b1;
                    mem_we        <= 1'b0;
                    mem_addr      <= pc;
                    pc_out        <= pc;
                    state         <= S_FETCH;
                end
                S_HALT, S_TRAP: state <= state;
                default: begin
                    halted <= 1'b1;
                    trap   <= 1'b1;
                    state  <= S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a wait-state memory model feeds small
// hand-assembled programs and observed fetches/stores are compared to hand-derived values.
module tb_mips_multicycle_core;

    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req, mem_we, mem_ack, halted, trap, instr_retired;
    logic [AW-1:0] mem_addr, pc_out;
    logic [31:0]   mem_wdata, mem_rdata;

    logic [31:0] mem [512];
    int          wait_states = 0;
    int          wait_cnt = 0;
    logic        spurious_ack = 1'b0;
    int          cycle_count = 0;
    int          retire_count = 0;
    int          halt_req_count = 0;
    int          unstable_count = 0;
    int          check_count = 0;
    int          pass_count = 0;
    logic        req_prev = 1'b0;
    logic [AW-1:0] hold_addr;
    logic          hold_we;
    logic [31:0]   hold_wdata;
    logic [31:0] read_addr[$];
    int          read_cycle[$];
    logic [31:0] store_addr[$];
    logic [31:0] store_data[$];

    mips_multicycle_core #(.ADDR_WIDTH(AW), .RESET_PC(32'h40), .NUM_REGS(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .trap(trap), .instr_retired(instr_retired), .pc_out(pc_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_count <= cycle_count + 1;

    // Memory model: acks after wait_states stall cycles, logs reads/stores, watches stability
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (instr_retired) retire_count++;
            if (halted && mem_req) halt_req_count++;
            if (reset_n && mem_req) begin
                if (req_prev && (mem_addr !== hold_addr || mem_we !== hold_we ||
                                 mem_wdata !== hold_wdata))
                    unstable_count++;
                if (wait_cnt >= wait_states) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[10:2]];
                    if (mem_we) begin
                        mem[mem_addr[10:2]] = mem_wdata;
                        store_addr.push_back(32'(mem_addr));
                        store_data.push_back(mem_wdata);
                    end else begin
                        read_addr.push_back(32'(mem_addr));
                        read_cycle.push_back(cycle_count);
                    end
                    wait_cnt = 0;
                    req_prev = 1'b0;
                end else begin
                    mem_ack    = 1'b0;
                    mem_rdata  = 32'hDEAD_BEEF;
                    wait_cnt++;
                    req_prev   = 1'b1;
                    hold_addr  = mem_addr;
                    hold_we    = mem_we;
                    hold_wdata = mem_wdata;
                end
            end else begin
                mem_ack   = spurious_ack;
                mem_rdata = 32'hDEAD_BEEF;
                wait_cnt  = 0;
                req_prev  = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] iType(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jType(input int byte_target);
        return {6'h02, 26'(byte_target >> 2)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic putWord(input int byte_addr, input logic [31:0] word);
        mem[byte_addr >> 2] = word;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    task automatic clearLogs();
        read_addr.delete();
        read_cycle.delete();
        store_addr.delete();
        store_data.delete();
        retire_count   = 0;
        halt_req_count = 0;
        unstable_count = 0;
    endtask

    // Hold reset, check reset-state outputs, release and check nothing is requested yet
    task automatic applyStimulus(input int waits);
        reset_n      = 1'b0;
        wait_states  = waits;
        spurious_ack = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        clearLogs();
        checkOutput("rst_req", 32'(mem_req), 0);
        checkOutput("rst_addr", 32'(mem_addr), 0);
        checkOutput("rst_halted", 32'(halted), 0);
        checkOutput("rst_trap", 32'(trap), 0);
        checkOutput("rst_retired", 32'(instr_retired), 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("pre_req", 32'(mem_req), 0);
        checkOutput("pre_wdata", mem_wdata, 0);
    endtask

    task automatic runUntilHalt(input int max_cycles);
        int n;
        n = 0;
        while (!halted && n < max_cycles) begin
            @(posedge clock);
            n++;
        end
        repeat (3) @(posedge clock);
        #2;
        checkOutput("halt_reached", 32'(halted), 1);
    endtask

    initial begin
        logic [31:0] exp_reads [20];
        logic [31:0] exp_st_addr [7];
        logic [31:0] exp_st_data [7];

        // Program A: ALU ops, stores, R0 discard, taken/not-taken BEQ, J, SYSCALL
        clearMem();
        putWord(32'h40, iType(8, 0, 1, 5));
        putWord(32'h44, iType(8, 0, 2, -3));
        putWord(32'h48, rType(1, 2, 3, 32'h20));
        putWord(32'h4C, rType(2, 1, 4, 32'h2A));
        putWord(32'h50, iType(32'h2B, 0, 3, 32'h200));
        putWord(32'h54, iType(32'h2B, 0, 4, 32'h204));
        putWord(32'h58, rType(1, 1, 0, 32'h20));
        putWord(32'h5C, iType(32'h2B, 0, 0, 32'h208));
        putWord(32'h60, iType(4, 1, 1, 2));
        putWord(32'h64, iType(8, 0, 6, 99));
        putWord(32'h68, iType(8, 0, 6, 98));
        putWord(32'h6C, iType(4, 1, 2, 5));
        putWord(32'h70, jType(32'h100));
        putWord(32'h100, rType(1, 2, 7, 32'h22));
        putWord(32'h104, rType(1, 2, 8, 32'h24));
        putWord(32'h108, rType(1, 2, 9, 32'h25));
        putWord(32'h10C, rType(1, 2, 10, 32'h2A));
        putWord(32'h110, iType(32'h2B, 0, 7, 32'h20C));
        putWord(32'h114, iType(32'h2B, 0, 8, 32'h210));
        putWord(32'h118, iType(32'h2B, 0, 9, 32'h214));
        putWord(32'h11C, iType(32'h2B, 0, 10, 32'h218));
        putWord(32'h120, 32'h0000_000C);
        applyStimulus(0);
        runUntilHalt(400);

        exp_reads = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C,
                      32'h60, 32'h6C, 32'h70, 32'h100, 32'h104, 32'h108, 32'h10C,
                      32'h110, 32'h114, 32'h118, 32'h11C, 32'h120};
        checkOutput("a_reads", 32'(read_addr.size()), 20);
        for (int i = 0; i < 20; i++)
            checkOutput($sformatf("a_fetch%0d", i), (i < read_addr.size()) ? read_addr[i] : 32'hFFFF_FFFF, exp_reads[i]);
        checkOutput("a_4instr_cycles", (read_cycle.size() > 4) ? 32'(read_cycle[4] - read_cycle[0]) : 0, 16);

        exp_st_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218};
        exp_st_data = '{32'd2, 32'd1, 32'd0, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd0};
        checkOutput("a_stores", 32'(store_addr.size()), 7);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("a_st_addr%0d", i), (i < store_addr.size()) ? store_addr[i] : 32'hFFFF_FFFF, exp_st_addr[i]);
            checkOutput($sformatf("a_st_data%0d", i), (i < store_data.size()) ? store_data[i] : 32'hFFFF_FFFF, exp_st_data[i]);
        end
        checkOutput("a_retired", 32'(retire_count), 19);
        checkOutput("a_syscall_trap", 32'(trap), 0);
        checkOutput("a_halt_req", 32'(mem_req), 0);

        // Program B: SW then LW with three wait states per access
        clearMem();
        putWord(32'h40, iType(8, 0, 1, 5));
        putWord(32'h44, iType(32'h2B, 0, 1, 8));
        putWord(32'h48, iType(32'h23, 0, 5, 8));
        putWord(32'h4C, iType(32'h2B, 0, 5, 32'h20));
        putWord(32'h50, 32'h0000_000C);
        applyStimulus(3);
        runUntilHalt(400);
        checkOutput("b_st0_addr", (store_addr.size() > 0) ? store_addr[0] : 32'hFFFF_FFFF, 32'h8);
        checkOutput("b_st0_data", (store_data.size() > 0) ? store_data[0] : 32'hFFFF_FFFF, 32'd5);
        checkOutput("b_lw_r5", (store_data.size() > 1) ? store_data[1] : 32'hFFFF_FFFF, 32'd5);
        checkOutput("b_lw_read", (read_addr.size() > 3) ? read_addr[3] : 32'hFFFF_FFFF, 32'h8);
        checkOutput("b_lw_cycles", (read_cycle.size() > 4) ? 32'(read_cycle[4] - read_cycle[2]) : 0, 11);
        checkOutput("b_stable", 32'(unstable_count), 0);
        checkOutput("b_retired", 32'(retire_count), 4);

        // Program C: illegal opcode traps; spurious acks afterwards must not wake the core
        clearMem();
        putWord(32'h40, {6'h3F, 26'h0});
        applyStimulus(0);
        runUntilHalt(50);
        spurious_ack = 1'b1;
        repeat (6) @(posedge clock);
        #2;
        checkOutput("c_trap", 32'(trap), 1);
        checkOutput("c_halted", 32'(halted), 1);
        checkOutput("c_req_after", 32'(halt_req_count), 0);
        checkOutput("c_reads", 32'(read_addr.size()), 1);
        checkOutput("c_retired", 32'(retire_count), 0);

        // Program D: misaligned LW at address 6
        clearMem();
        putWord(32'h40, iType(8, 0, 1, 6));
        putWord(32'h44, iType(32'h23, 1, 2, 0));
        applyStimulus(0);
        runUntilHalt(50);
        checkOutput("d_trap", 32'(trap), 1);
        checkOutput("d_reads", 32'(read_addr.size()), 2);
        checkOutput("d_retired", 32'(retire_count), 1);

        // Program E: reset asserted while a fetch is stalled, then a clean restart
        clearMem();
        putWord(32'h40, iType(8, 0, 1, 5));
        putWord(32'h44, 32'h0000_000C);
        applyStimulus(100);
        repeat (3) @(posedge clock);
        #2;
        checkOutput("e_req_pending", 32'(mem_req), 1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("e_rst_drop", 32'(mem_req), 0);
        checkOutput("e_rst_addr", 32'(mem_addr), 0);
        repeat (2) @(posedge clock);
        #2;
        clearLogs();
        wait_states = 0;
        @(negedge clock);
        reset_n = 1'b1;
        runUntilHalt(50);
        checkOutput("e_restart_addr", (read_addr.size() > 0) ? read_addr[0] : 32'hFFFF_FFFF, 32'h40);
        checkOutput("e_retired", 32'(retire_count), 1);
        checkOutput("e_trap", 32'(trap), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
